// File: rtl/knock_window_ctrl.sv
// Knock-window scheduler: time-shares one knock detector across cylinders and keeps per-cylinder ignition retard.
// Build option: define KNOCK_MISS_CNT_EN to count tdc_pulse requests dropped while busy.
module knock_window_ctrl #(
    parameter int NUM_CYL     = 4,
    parameter int CYL_W       = 2,
    parameter int WIN_DELAY   = 16,
    parameter int WIN_LEN     = 64,
    parameter int KNOCK_MIN   = 3,
    parameter int RETARD_STEP = 2,
    parameter int RETARD_MAX  = 20,
    parameter int RECOVER_WIN = 8,
    parameter int RET_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tdc_pulse,
    input  logic [CYL_W-1:0] tdc_cyl,
    input  logic             knock_detected,
    output logic [CYL_W-1:0] sensor_sel,
    output logic             win_open,
    output logic             busy,
    output logic             knock_event,
    output logic [CYL_W-1:0] event_cyl,
    input  logic [CYL_W-1:0] retard_rd_cyl,
    output logic [RET_W-1:0] retard_rd_val,
    output logic [7:0]       missed_tdc_cnt
);

    localparam int CNT_MAX = (WIN_DELAY > WIN_LEN) ? WIN_DELAY : WIN_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HIT_W   = $clog2(WIN_LEN + 1);
    localparam int CLN_W   = $clog2(RECOVER_WIN + 1);

    localparam logic [CYL_W:0]   NUM_CYL_L   = (CYL_W + 1)'(NUM_CYL);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(WIN_DELAY - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD    = CNT_W'(WIN_LEN - 1);
    localparam logic [HIT_W-1:0] HIT_SAT     = HIT_W'(WIN_LEN);
    localparam logic [HIT_W-1:0] KNOCK_MIN_L = HIT_W'(KNOCK_MIN);
    localparam logic [CLN_W-1:0] RECOVER_L   = CLN_W'(RECOVER_WIN);
    localparam logic [RET_W:0]   RET_STEP_L  = (RET_W + 1)'(RETARD_STEP);
    localparam logic [RET_W:0]   RET_MAX_L   = (RET_W + 1)'(RETARD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_WINDOW = 2'd2,
        ST_EVAL   = 2'd3
    } state_t;

    // One extra bit of headroom so the sum cannot wrap before the ceiling clamp.
    function automatic logic [RET_W-1:0] ret_inc(input logic [RET_W-1:0] r);
        logic [RET_W:0] sum;
        sum = {1'b0, r} + RET_STEP_L;
        if (sum > RET_MAX_L) begin
            ret_inc = RET_MAX_L[RET_W-1:0];
        end else begin
            ret_inc = sum[RET_W-1:0];
        end
    endfunction

    function automatic logic [RET_W-1:0] ret_dec(input logic [RET_W-1:0] r);
        if (r == '0) begin
            ret_dec = '0;
        end else begin
            ret_dec = r - RET_W'(1);
        end
    endfunction

    state_t             state_q, state_d;
    logic [CYL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic               win_open_q, win_open_d;
    logic               busy_q, busy_d;
    logic               knock_event_q, knock_event_d;
    logic [CYL_W-1:0]   event_cyl_q, event_cyl_d;
    logic [RET_W-1:0]   retard_q [NUM_CYL];
    logic [RET_W-1:0]   retard_d [NUM_CYL];
    logic [CLN_W-1:0]   clean_q [NUM_CYL];
    logic [CLN_W-1:0]   clean_d [NUM_CYL];
    logic [CLN_W-1:0]   clean_inc_s;

    // Next-state, window counters and retard bookkeeping.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        hit_d         = hit_q;
        knock_event_d = 1'b0;
        event_cyl_d   = event_cyl_q;
        retard_d      = retard_q;
        clean_d       = clean_q;
        clean_inc_s   = clean_q[sel_q] + CLN_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (tdc_pulse && ({1'b0, tdc_cyl} < NUM_CYL_L)) begin
                    state_d = ST_DELAY;
                    sel_d   = tdc_cyl;
                    hit_d   = '0;
                    cnt_d   = DELAY_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_WINDOW;
                    cnt_d   = WIN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WINDOW: begin
                if (knock_detected && (hit_q != HIT_SAT)) begin
                    hit_d = hit_q + HIT_W'(1);
                end else begin
                    hit_d = hit_q;
                end
                if (cnt_q == '0) begin
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EVAL: begin
                state_d     = ST_IDLE;
                event_cyl_d = sel_q;
                if (hit_q >= KNOCK_MIN_L) begin
                    retard_d[sel_q] = ret_inc(retard_q[sel_q]);
                    clean_d[sel_q]  = '0;
                    knock_event_d   = 1'b1;
                end else if (clean_inc_s == RECOVER_L) begin
                    retard_d[sel_q] = ret_dec(retard_q[sel_q]);
                    clean_d[sel_q]  = '0;
                end else begin
                    clean_d[sel_q] = clean_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        win_open_d = (state_d == ST_WINDOW);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            hit_q         <= '0;
            win_open_q    <= 1'b0;
            busy_q        <= 1'b0;
            knock_event_q <= 1'b0;
            event_cyl_q   <= '0;
            for (int i = 0; i < NUM_CYL; i++) begin
                retard_q[i] <= '0;
                clean_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            hit_q         <= hit_d;
            win_open_q    <= win_open_d;
            busy_q        <= busy_d;
            knock_event_q <= knock_event_d;
            event_cyl_q   <= event_cyl_d;
            retard_q      <= retard_d;
            clean_q       <= clean_d;
        end
    end

    assign sensor_sel    = sel_q;
    assign win_open      = win_open_q;
    assign busy          = busy_q;
    assign knock_event   = knock_event_q;
    assign event_cyl     = event_cyl_q;
    assign retard_rd_val = ({1'b0, retard_rd_cyl} < NUM_CYL_L) ? retard_q[retard_rd_cyl] : '0;

`ifdef KNOCK_MISS_CNT_EN
    logic [7:0] missed_q, missed_d;

    // Requests arriving outside IDLE are dropped; count them, saturating.
    always_comb begin
        if (tdc_pulse && (state_q != ST_IDLE) && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end else begin
            missed_d = missed_q;
        end
    end

    // Dropped-request counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            missed_q <= 8'd0;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign missed_tdc_cnt = missed_q;
`else
    assign missed_tdc_cnt = 8'd0;
`endif

endmodule

// File: doc/knock_window_ctrl.md
Name: knock_window_ctrl

Overview:
- Time-multiplexed knock-window scheduler and ignition-retard controller.
- Shares one knock filter/threshold detector across NUM_CYL cylinder sensors: selects the sensor, waits for filter settling, then opens a detection window and counts detector hits.
- Converts hits into per-cylinder ignition retard, with slow recovery after clean windows.
- Sits between the crank/TDC decoder and the shared knock detector; the retard values feed the ignition timing block.

Parameters:
- NUM_CYL, 4, number of cylinders/sensors (2..2^CYL_W).
- CYL_W, 2, cylinder index width.
- WIN_DELAY, 16, settling cycles after sensor switch, before the window opens (>=1).
- WIN_LEN, 64, window length in cycles (>=1).
- KNOCK_MIN, 3, window hits needed to declare knock (1..WIN_LEN).
- RETARD_STEP, 2, retard increment per knock event.
- RETARD_MAX, 20, retard ceiling (< 2^RET_W).
- RECOVER_WIN, 8, consecutive clean windows per cylinder before retard decrements by 1.
- RET_W, 5, retard value width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- tdc_pulse  in  1  one-cycle request: start window for tdc_cyl
- tdc_cyl  in  CYL_W  cylinder for this TDC
- knock_detected  in  1  registered output of shared detector
- sensor_sel  out  CYL_W  mux select to shared filter input
- win_open  out  1  high during WINDOW state
- busy  out  1  high in DELAY/WINDOW/EVAL
- knock_event  out  1  one-cycle pulse, knock declared
- event_cyl  out  CYL_W  cylinder of last evaluated window
- retard_rd_cyl  in  CYL_W  retard read address
- retard_rd_val  out  RET_W  combinational read of retard[retard_rd_cyl]
- missed_tdc_cnt  out  8  dropped-TDC counter (see Optional Feature)

Interface: reset reset, asynchronous, active-high; clock clk.

Behaviour:
- Reset: state IDLE, sensor_sel=0, win_open=0, busy=0, knock_event=0, event_cyl=0, all retard[]=0, all clean_cnt[]=0, hit counter=0, missed_tdc_cnt=0.
- States: IDLE, DELAY, WINDOW, EVAL.
- IDLE: on tdc_pulse with tdc_cyl < NUM_CYL, latch cyl, set sensor_sel=cyl, clear hit count, load delay counter, go to DELAY. An out-of-range tdc_cyl is ignored and the state stays IDLE.
- DELAY:
  - Lasts exactly WIN_DELAY cycles; knock_detected is ignored (filter flushing).
  - Then go to WINDOW.
- WINDOW:
  - Lasts exactly WIN_LEN cycles; win_open=1.
  - Each cycle with knock_detected=1 increments the hit count, saturating at WIN_LEN.
  - Then go to EVAL.
- EVAL (1 cycle):
  - If hits >= KNOCK_MIN: retard[cyl] = min(retard+RETARD_STEP, RETARD_MAX), clean_cnt[cyl]=0, knock_event=1 next cycle.
  - Else clean_cnt[cyl]++. When it reaches RECOVER_WIN: retard[cyl] = max(retard-1, 0), clean_cnt=0.
  - event_cyl=cyl. Go to IDLE.
- Timing (tdc_pulse at cycle 0):
  - busy and sensor_sel valid from cycle 1.
  - win_open in cycles WIN_DELAY+1 .. WIN_DELAY+WIN_LEN.
  - EVAL at cycle WIN_DELAY+WIN_LEN+1.
  - knock_event, updated retard and busy=0 at cycle WIN_DELAY+WIN_LEN+2.
  - The next tdc_pulse is accepted from that cycle.
- tdc_pulse while busy (including in EVAL): dropped, no effect on the current window.
- sensor_sel holds its last value in IDLE.
- Retard arithmetic must not wrap; both saturations are exact.
- Retard reads are combinational; an EVAL update is visible on the cycle after EVAL.
- Reset mid-operation: immediate return to the reset values above, including retard[].

Optional Feature:
- Macro KNOCK_MISS_CNT_EN.
- Defined: missed_tdc_cnt increments on each tdc_pulse dropped while busy, saturating at 255. Out-of-range tdc_cyl in IDLE is not counted. Cleared only by reset.
- Undefined: missed_tdc_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Reset -> all outputs 0, retard_rd_val=0 for cyl 0..3, busy=0.
- tdc_pulse cyl=2 at cycle 0, knock_detected high for 5 cycles inside the window -> win_open cycles 17..80, knock_event pulse at cycle 82 with event_cyl=2, retard[2]=2.
- tdc cyl=1, knock_detected high only during DELAY (cycles 1..16) plus 2 hits in the window -> no knock_event, retard[1] unchanged, clean_cnt advances.
- 11 consecutive knocking windows on cyl 1 -> retard steps 2,4,...,20, then stays 20.
- retard[0]=4, then 8 clean windows on cyl 0 -> retard[0]=3 after the 8th. A knock in between restarts the count.
- tdc_pulse during WINDOW -> ignored, window timing unaffected, missed_tdc_cnt=1 with KNOCK_MISS_CNT_EN, 0 without. Reset asserted mid-WINDOW -> busy=0, retard[] cleared.
